digit_counter: RTL and testbench
================================

# digit_counter

Parametrised multi-digit up/down counter with synchronous parallel load, selectable binary-hex or BCD digit arithmetic, wrap or saturate at the ends, and an on-board 7-segment decoder for every digit. It is the general-purpose successor to the fixed 16-bit enable-chained counter in the lab display path. It drives the HEX displays directly and gives neighbouring blocks a terminal-count strobe for cascading.

## Interface
Parameters:
- DIGITS, 4, number of 4-bit digits; must be 1..8.
- BCD, 0, digit arithmetic; 0 = hex (0..F), 1 = decimal (0..9).
- SAT, 0, end behaviour; 0 = wrap around, 1 = saturate and hold.

Ports:
- Clk  in  1  rising-edge clock.
- Clr  in  1  reset; asynchronous, active-high.
- En  in  1  count enable for this cycle.
- Up  in  1  direction; 1 = up, 0 = down.
- Load  in  1  synchronous parallel load; has priority over En.
- LoadVal  in  4*DIGITS  value to load; digit d occupies [4d+3:4d].
- Q  out  4*DIGITS  registered count value; digit 0 is least significant.
- Tc  out  1  terminal-count strobe, combinational.
- Ovf  out  1  sticky flag; set when a count is attempted at the end value.
- HEX  out  7*DIGITS  active-low segments; digit d, segment k (a=0 … g=6) at bit 7d+k.

## Operation
- Clr high → Q = 0 and Ovf = 0 immediately, without waiting for a clock edge. While Clr is high, Load and En are ignored.
- Each rising Clk edge with Clr low is handled in priority order:
  - Load: Q <= LoadVal, Ovf <= 0.
  - Else En & Up:
    - Q < MAX: Q <= Q+1.
    - Q == MAX: Q <= 0 if SAT=0, Q holds if SAT=1; Ovf <= 1 in both cases.
  - Else En & ~Up:
    - Q > 0: Q <= Q-1.
    - Q == 0: Q <= MAX if SAT=0, Q holds if SAT=1; Ovf <= 1 in both cases.
  - Else: Q and Ovf hold.
- MAX is every digit at F (BCD=0) or every digit at 9 (BCD=1).
- BCD=1 arithmetic:
  - Increment: a digit at 9 goes to 0 and carries into the next digit.
  - Decrement: a digit at 0 goes to 9 and borrows from the next digit.
  - Q never holds a digit above 9. On Load, any LoadVal nibble above 9 is clamped to 9.
- BCD=0 arithmetic is plain modulo-16^DIGITS binary.
- Tc = En & ~Load & ~Clr & (Up ? Q==MAX : Q==0). It is a cascade strobe for the next stage, valid in the same cycle.
- Ovf clears only on Clr or Load.
- Segment decode (lit segments per digit value):
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg
- Lit segment = 0 on HEX. HEX depends only on Q; BCD mode never presents A–F.

## Timing
- Reset values: Q = 0, Ovf = 0, every HEX digit shows "0" (segments a–f = 0, g = 1).
- Tc after reset is 0, except it is 1 when En=1 and Up=0 with Clr low (Q is already at the down terminal).
- Load-to-Q latency is 1 clock. Count-to-Q latency is 1 clock per enabled edge.
- HEX and Tc are combinational from registered state: valid in the same cycle Q changes, with no added latency.
- Clr deassertion must meet recovery/removal relative to Clk. The first count happens on the first edge after deassertion.
- Clr asserted mid-count wins immediately, with no partial update.
- Load and En high together: the load wins and the count is lost; Tc = 0 in that cycle.
- Changing Up while En is high takes effect on the next edge, with no dead cycle.
- Q is not a power-on default: with Clr never asserted, Q is undefined.

## Test plan
- DIGITS=4, BCD=0, SAT=0: Load 0xFFFE, then En=1, Up=1 for 3 edges → Q = FFFF, 0000, 0001. Tc=1 only while Q=FFFF. Ovf set after the wrap edge and stays set. HEX3 shows "0" segments after the wrap.
- BCD=1: Load 0x0099, then one up edge → Q = 0x0100. One down edge → 0x0099. Load 0x12AB → Q = 0x1299 and Ovf = 0.
- BCD=1, SAT=1: Q = 0, En=1, Up=0 for 2 edges → Q stays 0000, Ovf=1, Tc=1 throughout. A subsequent Load of 0x0005 clears Ovf.
- Load=1, En=1, Up=1 with LoadVal = 0x1234 on the same edge → Q = 0x1234, not 0x1235. Tc=0 during that cycle.
- Assert Clr asynchronously between edges while counting at Q = 0x00A7 → Q = 0 and Ovf = 0 before the next edge. No count occurs while Clr is high. Counting resumes at 0001 on the first edge after release.
- DIGITS=2, BCD=0: step through all 256 values upward. The HEX decode for every nibble matches the segment list in Operation, and the wrap occurs at 0xFF.

Source files
------------

// File: rtl/digit_counter.sv
// Multi-digit up/down counter with parallel load, hex or BCD digits,
// wrap or saturate at the ends, and a 7-segment decoder per digit.
module digit_counter #(
    parameter int unsigned DIGITS = 4,
    parameter bit          BCD    = 1'b0,
    parameter bit          SAT    = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Clr,
    input  logic                  En,
    input  logic                  Up,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadVal,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  Tc,
    output logic                  Ovf,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int unsigned   W      = 4 * DIGITS;
    localparam logic [3:0]    DigMax = BCD ? 4'd9 : 4'hF;
    localparam logic [W-1:0]  MaxVal = {DIGITS{DigMax}};

    logic [W-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] q_inc, q_dec, load_val;
    logic         inc_carry, dec_borrow;
    logic         at_max, at_zero;

    // Lit-segment mask, bit k = segment k (a=0 .. g=6).
    function automatic logic [6:0] seg_lit(input logic [3:0] v);
        logic [6:0] m;
        case (v)
            4'h0:    m = 7'h3F;
            4'h1:    m = 7'h06;
            4'h2:    m = 7'h5B;
            4'h3:    m = 7'h4F;
            4'h4:    m = 7'h66;
            4'h5:    m = 7'h6D;
            4'h6:    m = 7'h7D;
            4'h7:    m = 7'h07;
            4'h8:    m = 7'h7F;
            4'h9:    m = 7'h67;
            4'hA:    m = 7'h77;
            4'hB:    m = 7'h7C;
            4'hC:    m = 7'h39;
            4'hD:    m = 7'h5E;
            4'hE:    m = 7'h79;
            default: m = 7'h71;
        endcase
        return m;
    endfunction

    assign at_max  = (q_q == MaxVal);
    assign at_zero = (q_q == '0);

    // Digit-wise ripple increment/decrement; all-max wraps to zero and zero to all-max.
    always_comb begin
        q_inc      = q_q;
        q_dec      = q_q;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (inc_carry) begin
                if (q_q[4*d +: 4] == DigMax) begin
                    q_inc[4*d +: 4] = 4'd0;
                end else begin
                    q_inc[4*d +: 4] = q_q[4*d +: 4] + 4'd1;
                    inc_carry       = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (q_q[4*d +: 4] == 4'd0) begin
                    q_dec[4*d +: 4] = DigMax;
                end else begin
                    q_dec[4*d +: 4] = q_q[4*d +: 4] - 4'd1;
                    dec_borrow      = 1'b0;
                end
            end
        end
    end

    // Load value with BCD nibbles clamped to 9 so Q never holds an invalid digit.
    always_comb begin
        load_val = LoadVal;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (BCD && (LoadVal[4*d +: 4] > 4'd9)) begin
                load_val[4*d +: 4] = 4'd9;
            end
        end
    end

    // Next-state: load beats count; end-of-range attempts set the sticky flag.
    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (Load) begin
            q_d   = load_val;
            ovf_d = 1'b0;
        end else if (En) begin
            if (Up) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    if (!SAT) q_d = q_inc;
                end else begin
                    q_d = q_inc;
                end
            end else begin
                if (at_zero) begin
                    ovf_d = 1'b1;
                    if (!SAT) q_d = q_dec;
                end else begin
                    q_d = q_dec;
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    // Outputs: registered state plus same-cycle terminal strobe and segment decode.
    always_comb begin
        Q   = q_q;
        Ovf = ovf_q;
        Tc  = En & ~Load & ~Clr & (Up ? at_max : at_zero);
        HEX = '1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            HEX[7*d +: 7] = ~seg_lit(q_q[4*d +: 4]);
        end
    end

endmodule

// File: tb/tb_digit_counter.sv
// Self-checking bench: four counter configurations on shared stimulus, checked
// against an integer-valued reference model, table vectors and corner sequences.
module tb_digit_counter;

    logic        Clk = 1'b0;
    logic        Clr, En, Up, Load;
    logic [15:0] LoadVal;

    logic [15:0] q0, q1, q2;
    logic [7:0]  q3;
    logic [27:0] hex0, hex1, hex2;
    logic [13:0] hex3;
    logic        tc0, tc1, tc2, tc3, ovf0, ovf1, ovf2, ovf3;

    // 0: hex wrap, 1: BCD wrap, 2: BCD saturate, 3: 2-digit hex wrap
    digit_counter #(.DIGITS(4), .BCD(1'b0), .SAT(1'b0)) u_hex (
        .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal),
        .Q(q0), .Tc(tc0), .Ovf(ovf0), .HEX(hex0));
    digit_counter #(.DIGITS(4), .BCD(1'b1), .SAT(1'b0)) u_bcd (
        .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal),
        .Q(q1), .Tc(tc1), .Ovf(ovf1), .HEX(hex1));
    digit_counter #(.DIGITS(4), .BCD(1'b1), .SAT(1'b1)) u_bcd_sat (
        .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal),
        .Q(q2), .Tc(tc2), .Ovf(ovf2), .HEX(hex2));
    digit_counter #(.DIGITS(2), .BCD(1'b0), .SAT(1'b0)) u_hex2 (
        .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal[7:0]),
        .Q(q3), .Tc(tc3), .Ovf(ovf3), .HEX(hex3));

    always #5 Clk = ~Clk;

    logic [31:0] q_a [4];
    logic [31:0] hex_a [4];
    logic        tc_a [4];
    logic        ovf_a [4];
    assign q_a[0] = {16'h0, q0};
    assign q_a[1] = {16'h0, q1};
    assign q_a[2] = {16'h0, q2};
    assign q_a[3] = {24'h0, q3};
    assign hex_a[0] = {4'h0, hex0};
    assign hex_a[1] = {4'h0, hex1};
    assign hex_a[2] = {4'h0, hex2};
    assign hex_a[3] = {18'h0, hex3};
    assign tc_a[0] = tc0;
    assign tc_a[1] = tc1;
    assign tc_a[2] = tc2;
    assign tc_a[3] = tc3;
    assign ovf_a[0] = ovf0;
    assign ovf_a[1] = ovf1;
    assign ovf_a[2] = ovf2;
    assign ovf_a[3] = ovf3;

    // Reference model: count held as a plain integer in radix base^digits.
    int unsigned digs [4] = '{4, 4, 4, 2};
    int unsigned base [4] = '{16, 10, 10, 16};
    bit          sat  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int unsigned cnt  [4];
    bit          ovf_m [4];

    string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg",
                         "aefg"};

    int n_cmp = 0;
    int n_err = 0;

    function automatic int unsigned max_of(int i);
        int unsigned m = 1;
        for (int d = 0; d < int'(digs[i]); d++) m = m * base[i];
        return m - 1;
    endfunction

    function automatic logic [31:0] to_q(int i, int unsigned v);
        logic [31:0] r = '0;
        for (int d = 0; d < int'(digs[i]); d++) begin
            r[4*d +: 4] = 4'(v % base[i]);
            v = v / base[i];
        end
        return r;
    endfunction

    function automatic int unsigned from_lv(int i, logic [15:0] lv);
        int unsigned v = 0, mult = 1, nib;
        for (int d = 0; d < int'(digs[i]); d++) begin
            nib = int'(lv[4*d +: 4]);
            if (nib >= base[i]) nib = base[i] - 1;
            v = v + nib * mult;
            mult = mult * base[i];
        end
        return v;
    endfunction

    function automatic logic [6:0] lit_mask(int v);
        logic [6:0] m = '0;
        string s = segs[v];
        for (int k = 0; k < s.len(); k++) m[s[k] - "a"] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_hex(int i);
        logic [31:0] r = '0;
        logic [31:0] qv = to_q(i, cnt[i]);
        for (int d = 0; d < int'(digs[i]); d++) r[7*d +: 7] = ~lit_mask(int'(qv[4*d +: 4]));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            cnt[i]   = 0;
            ovf_m[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        logic tc_e;
        for (int i = 0; i < 4; i++) begin
            tc_e = En & ~Load & ~Clr & (Up ? (cnt[i] == max_of(i)) : (cnt[i] == 0));
            chk($sformatf("q[%0d]", i), q_a[i], to_q(i, cnt[i]));
            chk($sformatf("ovf[%0d]", i), {31'h0, ovf_a[i]}, {31'h0, ovf_m[i]});
            chk($sformatf("tc[%0d]", i), {31'h0, tc_a[i]}, {31'h0, tc_e});
            chk($sformatf("hex[%0d]", i), hex_a[i], exp_hex(i));
        end
    endtask

    task automatic drive(input logic l, input logic e, input logic u, input logic [15:0] lv);
        @(negedge Clk);
        Load = l; En = e; Up = u; LoadVal = lv;
        #1 check_all();
    endtask

    // Advance one rising edge and apply the spec rules to the model.
    task automatic edge_upd();
        @(posedge Clk);
        for (int i = 0; i < 4; i++) begin
            if (Clr) begin
                cnt[i] = 0; ovf_m[i] = 1'b0;
            end else if (Load) begin
                cnt[i] = from_lv(i, LoadVal); ovf_m[i] = 1'b0;
            end else if (En && Up) begin
                if (cnt[i] == max_of(i)) begin
                    ovf_m[i] = 1'b1;
                    if (!sat[i]) cnt[i] = 0;
                end else cnt[i]++;
            end else if (En) begin
                if (cnt[i] == 0) begin
                    ovf_m[i] = 1'b1;
                    if (!sat[i]) cnt[i] = max_of(i);
                end else cnt[i]--;
            end
        end
        #1;
    endtask

    typedef struct {
        logic        ld, en, up;
        logic [15:0] lv;
        logic        tc;   // inst 0, before the edge
        logic [15:0] q;    // inst 0, after the edge
        logic        ovf;  // inst 0, after the edge
    } vec_t;
    vec_t tbl [7];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0001, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h1234, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h1233, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h1233, 1'b0};

        Clr = 1'b1; En = 1'b0; Up = 1'b0; Load = 1'b0; LoadVal = '0;
        model_clear();
        #2 check_all();

        // Release; Tc is already high for a downward count at zero.
        @(negedge Clk);
        Clr = 1'b0; En = 1'b1; Up = 1'b0;
        #1 chk("tc_after_reset", {31'h0, tc0}, 32'h1);
        check_all();
        En = 1'b0;
        #1 check_all();

        // Table vectors
        for (int k = 0; k < 7; k++) begin
            drive(tbl[k].ld, tbl[k].en, tbl[k].up, tbl[k].lv);
            chk($sformatf("vec%0d_tc", k), {31'h0, tc0}, {31'h0, tbl[k].tc});
            edge_upd();
            chk($sformatf("vec%0d_q", k), {16'h0, q0}, {16'h0, tbl[k].q});
            chk($sformatf("vec%0d_ovf", k), {31'h0, ovf0}, {31'h0, tbl[k].ovf});
            if (k == 2) chk("hex3_after_wrap", {25'h0, hex0[27:21]}, 32'h40);
        end

        // BCD carry/borrow and load clamp
        drive(1'b1, 1'b0, 1'b0, 16'h0099); edge_upd();
        drive(1'b0, 1'b1, 1'b1, 16'h0000); edge_upd();
        chk("bcd_carry", {16'h0, q1}, 32'h0100);
        drive(1'b0, 1'b1, 1'b0, 16'h0000); edge_upd();
        chk("bcd_borrow", {16'h0, q1}, 32'h0099);
        drive(1'b1, 1'b0, 1'b0, 16'h12AB); edge_upd();
        chk("bcd_clamp", {16'h0, q1}, 32'h1299);
        chk("bcd_clamp_ovf", {31'h0, ovf1}, 32'h0);

        // BCD saturate at zero
        drive(1'b1, 1'b0, 1'b0, 16'h0000); edge_upd();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0000);
            chk("sat_tc", {31'h0, tc2}, 32'h1);
            edge_upd();
            chk("sat_hold", {16'h0, q2}, 32'h0);
            chk("sat_ovf", {31'h0, ovf2}, 32'h1);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0005); edge_upd();
        chk("sat_load_q", {16'h0, q2}, 32'h5);
        chk("sat_load_ovf", {31'h0, ovf2}, 32'h0);

        // Asynchronous clear mid-count
        drive(1'b1, 1'b0, 1'b0, 16'h00A6); edge_upd();
        drive(1'b0, 1'b1, 1'b1, 16'h0000); edge_upd();
        chk("pre_clr_q", {16'h0, q0}, 32'h00A7);
        @(negedge Clk);
        #2 Clr = 1'b1;
        model_clear();
        #1 chk("clr_async_q", {16'h0, q0}, 32'h0);
        chk("clr_async_ovf", {31'h0, ovf0}, 32'h0);
        chk("clr_tc", {31'h0, tc0}, 32'h0);
        edge_upd();
        chk("clr_hold_q", {16'h0, q0}, 32'h0);
        @(negedge Clk);
        Clr = 1'b0;
        #1 check_all();
        edge_upd();
        chk("clr_resume_q", {16'h0, q0}, 32'h1);

        // Full sweep of the 2-digit hex counter, including the wrap at FF
        drive(1'b1, 1'b0, 1'b0, 16'h0000); edge_upd();
        for (int k = 0; k < 256; k++) begin
            drive(1'b0, 1'b1, 1'b1, 16'h0000);
            edge_upd();
            chk("sweep_q3", {24'h0, q3}, 32'((k + 1) % 256));
        end

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] lv;
            case ($urandom_range(0, 3))
                0:       lv = 16'hFFFF;
                1:       lv = 16'h0000;
                2:       lv = 16'h9999;
                default: lv = 16'($urandom);
            endcase
            @(negedge Clk);
            if ($urandom_range(0, 39) == 0) begin
                Clr = 1'b1;
                model_clear();
            end else begin
                Clr = 1'b0;
            end
            Load = ($urandom_range(0, 15) == 0);
            En = ($urandom_range(0, 3) != 0);
            Up = 1'($urandom_range(0, 1));
            LoadVal = lv;
            #1 check_all();
            edge_upd();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
